// File: rtl/dir_controller.sv
// rtl/dir_controller.sv - directory coherence controller, one transaction in flight; optional DIR_STATS_EN emit counters
module dir_controller #(
    parameter int NUM_PROCS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int DATA_W      = 16,
    localparam int PW = $clog2(NUM_PROCS),
    localparam int AW = $clog2(NUM_ENTRIES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_type,
    input  logic [PW-1:0]     req_src,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              emit_valid,
    input  logic              emit_ready,
    output logic [5:0]        emit_type,
    output logic [PW-1:0]     emit_dst,
    output logic [AW-1:0]     emit_addr,
    output logic [DATA_W-1:0] emit_data,
`ifdef DIR_STATS_EN
    output logic [15:0]       stat_inv,
    output logic [15:0]       stat_fetch,
`endif
    output logic              busy
);
    localparam logic [5:0] T_WMISS = 6'b000000;
    localparam logic [5:0] T_RMISS = 6'b000001;
    localparam logic [5:0] T_WB    = 6'b000101;
    localparam logic [5:0] T_INV   = 6'b000100;
    localparam logic [5:0] T_FETCH = 6'b100111;
    localparam logic [5:0] T_FINV  = 6'b100110;
    localparam logic [5:0] T_REPLY = 6'b000110;

    localparam logic [1:0] S_UNC = 2'b00;
    localparam logic [1:0] S_SHD = 2'b01;
    localparam logic [1:0] S_EXC = 2'b10;

    typedef enum logic [2:0] {IDLE, LOOKUP, INV, FETCH, WAIT_WB, REPLY} fsm_t;
    fsm_t state, state_n;

    logic [1:0]           ent_state [NUM_ENTRIES];
    logic [NUM_PROCS-1:0] ent_sh    [NUM_ENTRIES];
    logic [DATA_W-1:0]    ent_mem   [NUM_ENTRIES];

    logic [5:0]           cur_type;
    logic [PW-1:0]        cur_src, owner, owner_n;
    logic [AW-1:0]        cur_addr;
    logic [DATA_W-1:0]    cur_data;
    logic [NUM_PROCS-1:0] pending, pending_n, new_sh, new_sh_n;
    logic [1:0]           new_state, new_state_n;

    logic                 emit_valid_n;
    logic [5:0]           emit_type_n;
    logic [PW-1:0]        emit_dst_n;
    logic [AW-1:0]        emit_addr_n;
    logic [DATA_W-1:0]    emit_data_n;

    logic                 ent_we, mem_we;
    logic [1:0]           ent_wstate;
    logic [NUM_PROCS-1:0] ent_wsh;
    logic [DATA_W-1:0]    mem_wdata;

    logic [1:0]           e_state;
    logic [NUM_PROCS-1:0] e_sh, src_bit, dst_bit, pend_lk, pend_rem;
    logic [DATA_W-1:0]    e_mem;
    logic [PW-1:0]        e_owner;

    // Lowest set bit; gives the owner of a one-hot vector and the ascending invalidate order.
    function automatic logic [PW-1:0] first_set(input logic [NUM_PROCS-1:0] v);
        first_set = '0;
        for (int i = NUM_PROCS - 1; i >= 0; i--) begin
            if (v[i]) first_set = PW'(i);
        end
    endfunction

    assign e_state  = ent_state[cur_addr];
    assign e_sh     = ent_sh[cur_addr];
    assign e_mem    = ent_mem[cur_addr];
    assign e_owner  = first_set(e_sh);
    assign src_bit  = NUM_PROCS'(1) << cur_src;
    assign dst_bit  = NUM_PROCS'(1) << emit_dst;
    assign pend_lk  = e_sh & ~src_bit;
    assign pend_rem = pending & ~dst_bit;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n      = state;
        req_ready    = 1'b0;
        emit_valid_n = emit_valid;
        emit_type_n  = emit_type;
        emit_dst_n   = emit_dst;
        emit_addr_n  = emit_addr;
        emit_data_n  = emit_data;
        pending_n    = pending;
        owner_n      = owner;
        new_state_n  = new_state;
        new_sh_n     = new_sh;
        ent_we       = 1'b0;
        ent_wstate   = S_UNC;
        ent_wsh      = '0;
        mem_we       = 1'b0;
        mem_wdata    = cur_data;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = LOOKUP;
            end
            LOOKUP: begin
                state_n = IDLE;
                if (cur_type == T_RMISS || cur_type == T_WMISS) begin
                    emit_valid_n = 1'b1;
                    emit_addr_n  = cur_addr;
                    emit_type_n  = T_REPLY;
                    emit_dst_n   = cur_src;
                    emit_data_n  = e_mem;
                    state_n      = REPLY;
                end
                case (cur_type)
                    T_RMISS: begin
                        new_state_n = S_SHD;
                        new_sh_n    = e_sh | src_bit;
                        if (e_state == S_EXC) begin
                            owner_n     = e_owner;
                            emit_type_n = T_FETCH;
                            emit_dst_n  = e_owner;
                            emit_data_n = '0;
                            state_n     = FETCH;
                        end
                    end
                    T_WMISS: begin
                        new_state_n = S_EXC;
                        new_sh_n    = src_bit;
                        if (e_state == S_SHD && pend_lk != '0) begin
                            pending_n   = pend_lk;
                            emit_type_n = T_INV;
                            emit_dst_n  = first_set(pend_lk);
                            emit_data_n = '0;
                            state_n     = INV;
                        end else if (e_state == S_EXC && e_owner != cur_src) begin
                            owner_n     = e_owner;
                            emit_type_n = T_FINV;
                            emit_dst_n  = e_owner;
                            emit_data_n = '0;
                            state_n     = FETCH;
                        end
                    end
                    T_WB: begin
                        // Voluntary write-back from the owner empties the entry; anything else is stale.
                        if (e_state == S_EXC && e_owner == cur_src) begin
                            ent_we = 1'b1;
                            mem_we = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            INV: begin
                if (emit_ready) begin
                    pending_n = pend_rem;
                    if (pend_rem != '0) begin
                        emit_dst_n = first_set(pend_rem);
                    end else begin
                        emit_type_n = T_REPLY;
                        emit_dst_n  = cur_src;
                        emit_data_n = e_mem;
                        state_n     = REPLY;
                    end
                end
            end
            FETCH: begin
                if (emit_ready) begin
                    emit_valid_n = 1'b0;
                    emit_type_n  = '0;
                    emit_dst_n   = '0;
                    emit_addr_n  = '0;
                    state_n      = WAIT_WB;
                end
            end
            WAIT_WB: begin
                req_ready = (req_type == T_WB) && (req_src == owner) && (req_addr == cur_addr);
                if (req_valid && req_ready) begin
                    mem_we       = 1'b1;
                    mem_wdata    = req_data;
                    emit_valid_n = 1'b1;
                    emit_type_n  = T_REPLY;
                    emit_dst_n   = cur_src;
                    emit_addr_n  = cur_addr;
                    emit_data_n  = req_data;
                    state_n      = REPLY;
                end
            end
            REPLY: begin
                if (emit_ready) begin
                    ent_we       = 1'b1;
                    ent_wstate   = new_state;
                    ent_wsh      = new_sh;
                    emit_valid_n = 1'b0;
                    emit_type_n  = '0;
                    emit_dst_n   = '0;
                    emit_addr_n  = '0;
                    emit_data_n  = '0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            emit_valid <= 1'b0;
            emit_type  <= '0;
            emit_dst   <= '0;
            emit_addr  <= '0;
            emit_data  <= '0;
            cur_type   <= '0;
            cur_src    <= '0;
            cur_addr   <= '0;
            cur_data   <= '0;
            owner      <= '0;
            pending    <= '0;
            new_state  <= S_UNC;
            new_sh     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_state[i] <= S_UNC;
                ent_sh[i]    <= '0;
                ent_mem[i]   <= '0;
            end
        end else begin
            state      <= state_n;
            emit_valid <= emit_valid_n;
            emit_type  <= emit_type_n;
            emit_dst   <= emit_dst_n;
            emit_addr  <= emit_addr_n;
            emit_data  <= emit_data_n;
            owner      <= owner_n;
            pending    <= pending_n;
            new_state  <= new_state_n;
            new_sh     <= new_sh_n;
            if (state == IDLE && req_valid) begin
                cur_type <= req_type;
                cur_src  <= req_src;
                cur_addr <= req_addr;
                cur_data <= req_data;
            end
            if (ent_we) begin
                ent_state[cur_addr] <= ent_wstate;
                ent_sh[cur_addr]    <= ent_wsh;
            end
            if (mem_we) ent_mem[cur_addr] <= mem_wdata;
        end
    end

`ifdef DIR_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_inv   <= '0;
            stat_fetch <= '0;
        end else if (emit_valid && emit_ready) begin
            if (emit_type == T_INV && stat_inv != 16'hFFFF)
                stat_inv <= stat_inv + 16'd1;
            if ((emit_type == T_FETCH || emit_type == T_FINV) && stat_fetch != 16'hFFFF)
                stat_fetch <= stat_fetch + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dir_controller.sv
// tb/tb_dir_controller.sv - directed table-driven bench for dir_controller
module tb_dir_controller;
    localparam logic [5:0] WM  = 6'b000000;
    localparam logic [5:0] RD  = 6'b000001;
    localparam logic [5:0] WB  = 6'b000101;
    localparam logic [5:0] INV = 6'b000100;
    localparam logic [5:0] FET = 6'b100111;
    localparam logic [5:0] FIN = 6'b100110;
    localparam logic [5:0] REP = 6'b000110;

    logic        clock = 0, reset = 1;
    logic        req_valid = 0, req_ready;
    logic [5:0]  req_type = 0;
    logic [1:0]  req_src = 0;
    logic [3:0]  req_addr = 0;
    logic [15:0] req_data = 0;
    logic        emit_valid, emit_ready = 1;
    logic [5:0]  emit_type;
    logic [1:0]  emit_dst;
    logic [3:0]  emit_addr;
    logic [15:0] emit_data;
    logic        busy;

    int errors = 0;
    int n_checks = 0;

    dir_controller dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_src(req_src), .req_addr(req_addr), .req_data(req_data),
        .emit_valid(emit_valid), .emit_ready(emit_ready), .emit_type(emit_type),
        .emit_dst(emit_dst), .emit_addr(emit_addr), .emit_data(emit_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [5:0]       typ;
        logic [1:0]       src;
        logic [3:0]       addr;
        logic [15:0]      data;
        logic [1:0]       n;
        logic             eb;
        logic [2:0][5:0]  et;
        logic [2:0][1:0]  ed;
        logic [2:0][15:0] ex;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] t, input int s, input int a, input logic [15:0] d,
                                input int n, input bit eb,
                                input logic [5:0] t0, input int d0, input logic [15:0] x0,
                                input logic [5:0] t1, input int d1, input logic [15:0] x1,
                                input logic [5:0] t2, input int d2, input logic [15:0] x2);
        vec_t v;
        v.typ = t; v.src = 2'(s); v.addr = 4'(a); v.data = d; v.n = 2'(n); v.eb = eb;
        v.et[0] = t0; v.ed[0] = 2'(d0); v.ex[0] = x0;
        v.et[1] = t1; v.ed[1] = 2'(d1); v.ex[1] = x1;
        v.et[2] = t2; v.ed[2] = 2'(d2); v.ex[2] = x2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [5:0] t, input logic [1:0] s, input logic [3:0] a,
                        input logic [15:0] d, input string tag);
        bit ok = 0;
        req_valid = 1; req_type = t; req_src = s; req_addr = a; req_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (req_ready) begin
                @(posedge clock);
                ok = 1;
            end else begin
                @(negedge clock);
            end
        end
        #1 req_valid = 0;
        check({tag, "_accepted"}, 32'(ok), 1);
    endtask

    // Collect emits until the FSM idles (or parks in WAIT_WB when eb is set).
    task automatic collect(input vec_t v, input string tag, input bit lat);
        int got = 0;
        int first = -1;
        bit done = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clock);
            if (c == 1 && lat) check({tag, "_busy_lookup"}, 32'(busy), 1);
            if (emit_valid && emit_ready) begin
                if (first < 0) first = c;
                if (got < int'(v.n)) begin
                    check($sformatf("%s_e%0d_type", tag, got), 32'(emit_type), 32'(v.et[got]));
                    check($sformatf("%s_e%0d_dst", tag, got), 32'(emit_dst), 32'(v.ed[got]));
                    check($sformatf("%s_e%0d_addr", tag, got), 32'(emit_addr), 32'(v.addr));
                    if (v.et[got] == REP)
                        check($sformatf("%s_e%0d_data", tag, got), 32'(emit_data), 32'(v.ex[got]));
                end
                got++;
            end
            if (v.eb) done = (got >= int'(v.n)) && !emit_valid && busy;
            else      done = !busy;
        end
        check({tag, "_completed"}, 32'(done), 1);
        check({tag, "_emit_count"}, 32'(got), 32'(v.n));
        if (lat && v.n != 0) check({tag, "_first_emit_latency_ok"}, 32'(first >= 1 && first <= 2), 1);
    endtask

    task automatic run(input vec_t v, input string tag, input bit lat);
        send(v.typ, v.src, v.addr, v.data, tag);
        collect(v, tag, lat);
    endtask

    vec_t vecs[25];
    vec_t h;

    initial begin
        vecs[0]  = mk(RD, 1, 3, 16'h0,    1, 0, REP, 1, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[1]  = mk(WM, 0, 3, 16'h0,    2, 0, INV, 1, 16'h0,    REP, 0, 16'h0, 0, 0, 0);
        vecs[2]  = mk(RD, 0, 5, 16'h0,    1, 0, REP, 0, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[3]  = mk(RD, 2, 5, 16'h0,    1, 0, REP, 2, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[4]  = mk(RD, 3, 5, 16'h0,    1, 0, REP, 3, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[5]  = mk(WM, 2, 5, 16'h0,    3, 0, INV, 0, 16'h0,    INV, 3, 16'h0, REP, 2, 16'h0);
        vecs[6]  = mk(RD, 1, 5, 16'h0,    1, 1, FET, 2, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[7]  = mk(WB, 2, 5, 16'h1234, 1, 0, REP, 1, 16'h1234, 0, 0, 0,     0, 0, 0);
        vecs[8]  = mk(WM, 1, 7, 16'h0,    1, 0, REP, 1, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[9]  = mk(RD, 0, 7, 16'h0,    1, 1, FET, 1, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[10] = mk(WB, 1, 7, 16'hBEEF, 1, 0, REP, 0, 16'hBEEF, 0, 0, 0,     0, 0, 0);
        vecs[11] = mk(WM, 3, 7, 16'h0,    3, 0, INV, 0, 16'h0,    INV, 1, 16'h0, REP, 3, 16'hBEEF);
        vecs[12] = mk(WM, 3, 7, 16'h0,    1, 0, REP, 3, 16'hBEEF, 0, 0, 0,     0, 0, 0);
        vecs[13] = mk(WM, 0, 7, 16'h0,    1, 1, FIN, 3, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[14] = mk(WB, 3, 7, 16'h5555, 1, 0, REP, 0, 16'h5555, 0, 0, 0,     0, 0, 0);
        vecs[15] = mk(WB, 0, 7, 16'h7777, 0, 0, 0, 0, 0,          0, 0, 0,     0, 0, 0);
        vecs[16] = mk(RD, 2, 7, 16'h0,    1, 0, REP, 2, 16'h7777, 0, 0, 0,     0, 0, 0);
        vecs[17] = mk(WM, 1, 7, 16'h0,    2, 0, INV, 2, 16'h0,    REP, 1, 16'h7777, 0, 0, 0);
        vecs[18] = mk(WB, 2, 7, 16'h9999, 0, 0, 0, 0, 0,          0, 0, 0,     0, 0, 0);
        vecs[19] = mk(WM, 1, 7, 16'h0,    1, 0, REP, 1, 16'h7777, 0, 0, 0,     0, 0, 0);
        vecs[20] = mk(6'h3F, 0, 7, 16'h0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 0, 0);
        vecs[21] = mk(WM, 2, 7, 16'h0,    1, 1, FIN, 1, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[22] = mk(WB, 1, 7, 16'h0AAA, 1, 0, REP, 2, 16'h0AAA, 0, 0, 0,     0, 0, 0);
        vecs[23] = mk(RD, 2, 9, 16'h0,    1, 0, REP, 2, 16'h0,    0, 0, 0,     0, 0, 0);
        vecs[24] = mk(WM, 2, 9, 16'h0,    1, 0, REP, 2, 16'h0,    0, 0, 0,     0, 0, 0);

        #12;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_emit_valid", 32'(emit_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_emit_type", 32'(emit_type), 0);
        check("rst_emit_dst_addr_data", {emit_dst, emit_addr, emit_data}, 0);
        @(negedge clock);
        reset = 0;

        for (int i = 0; i < 25; i++) run(vecs[i], $sformatf("v%0d", i), 1);

        // Stalled invalidate: outputs frozen, no request accepted.
        run(mk(RD, 0, 11, 0, 1, 0, REP, 0, 0, 0, 0, 0, 0, 0, 0), "s0", 1);
        run(mk(RD, 1, 11, 0, 1, 0, REP, 1, 0, 0, 0, 0, 0, 0, 0), "s1", 1);
        run(mk(RD, 3, 11, 0, 1, 0, REP, 3, 0, 0, 0, 0, 0, 0, 0), "s3", 1);
        emit_ready = 0;
        send(WM, 2'd2, 4'd11, 16'h0, "stall");
        begin
            bit seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clock);
                seen = emit_valid;
            end
            check("stall_emit_seen", 32'(seen), 1);
        end
        req_valid = 1; req_type = RD; req_src = 2'd0; req_addr = 4'd1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall_req_ready_%0d", k), 32'(req_ready), 0);
            @(negedge clock);
            check($sformatf("stall_valid_%0d", k), 32'(emit_valid), 1);
            check($sformatf("stall_msg_%0d", k), {emit_type, emit_dst, emit_addr}, {INV, 2'd0, 4'd11});
        end
        req_valid = 0;
        emit_ready = 1;
        h = mk(WM, 2, 11, 0, 3, 0, INV, 1, 0, INV, 3, 0, REP, 2, 0);
        collect(h, "stall_rest", 0);

        // Reset while parked in WAIT_WB.
        run(mk(WM, 1, 4, 0, 1, 0, REP, 1, 0, 0, 0, 0, 0, 0, 0), "w0", 1);
        run(mk(RD, 0, 4, 0, 1, 1, FET, 1, 0, 0, 0, 0, 0, 0, 0), "w1", 1);
        req_valid = 1; req_type = WB; req_src = 2'd2; req_addr = 4'd4;
        #1 check("wwb_wrong_src", 32'(req_ready), 0);
        req_src = 2'd1; req_addr = 4'd5;
        #1 check("wwb_wrong_addr", 32'(req_ready), 0);
        req_type = RD; req_addr = 4'd4;
        #1 check("wwb_wrong_type", 32'(req_ready), 0);
        req_type = WB;
        #1 check("wwb_match", 32'(req_ready), 1);
        req_valid = 0;
        @(negedge clock);
        check("wwb_busy_before_reset", 32'(busy), 1);
        #2 reset = 1;
        #1;
        check("arst_emit_valid", 32'(emit_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_req_ready", 32'(req_ready), 1);
        @(negedge clock);
        reset = 0;
        run(mk(RD, 1, 3, 0, 1, 0, REP, 1, 0, 0, 0, 0, 0, 0, 0), "r3", 1);
        run(mk(RD, 0, 4, 0, 1, 0, REP, 0, 0, 0, 0, 0, 0, 0, 0), "r4", 1);
        run(mk(RD, 1, 5, 0, 1, 0, REP, 1, 0, 0, 0, 0, 0, 0, 0), "r5", 1);
        run(mk(WM, 0, 3, 0, 2, 0, INV, 1, 0, REP, 0, 0, 0, 0, 0), "r3w", 1);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end
endmodule
